// File: rtl/pps_trace_defs.sv
// Shared definitions for the PPS writeback trace buffer.
// Optional timestamp field is enabled with the PPS_TRACE_TS_EN macro.
package pps_trace_defs;

    typedef enum logic [1:0] {
        TRC_IDLE = 2'd0,
        TRC_PRE  = 2'd1,
        TRC_POST = 2'd2,
        TRC_DONE = 2'd3
    } trc_state_e;

`ifdef PPS_TRACE_TS_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif

    // Record layout, MSB to LSB: pc, rd, regwrite, data, ts
    function automatic int rec_w(input int pc_w, input int rd_w, input int data_w);
        return pc_w + rd_w + 1 + data_w + TS_W;
    endfunction

    function automatic int rec_data_lsb();
        return TS_W;
    endfunction

    function automatic int rec_we_bit(input int data_w);
        return TS_W + data_w;
    endfunction

    function automatic int rec_rd_lsb(input int data_w);
        return TS_W + data_w + 1;
    endfunction

    function automatic int rec_pc_lsb(input int rd_w, input int data_w);
        return TS_W + data_w + 1 + rd_w;
    endfunction

endpackage

// File: rtl/pps_trace_ram.sv
// Single-port synchronous trace RAM; kept standalone so an SRAM macro can
// be dropped in. Read data is registered and only updates on a read access.
module pps_trace_ram #(
    parameter int DEPTH = 64,
    parameter int REC_W = 70,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [REC_W-1:0] wdata,
    output logic [REC_W-1:0] rdata
);

    logic [REC_W-1:0] mem [DEPTH];

    // One access per cycle: write when we, otherwise read into rdata
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/pps_trace_buf.sv
// Writeback-stage trace capture: circular buffer with arm / trigger /
// post-trigger window, read out by a 1-cycle-latency pop interface.
// Define PPS_TRACE_TS_EN to append a 16-bit free-running timestamp.
module pps_trace_buf
    import pps_trace_defs::*;
#(
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int RD_W      = 5,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32,
    localparam int REC_W    = rec_w(PC_W, RD_W, DATA_W),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic [RD_W-1:0]   wb_rd,
    input  logic              wb_regwrite,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              arm,
    input  logic              trig_pc_en,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic              trig_ext,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [REC_W-1:0]  rd_data,
    output logic [AW:0]       count,
    output logic [1:0]        state,
    output logic              triggered
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   POST_LD  = (AW+1)'(POST_TRIG);

    trc_state_e       state_q, state_d;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count_q, post_cnt;
    logic             trig_q, rd_valid_q;
    logic [REC_W-1:0] wr_rec, ram_q;
    logic             wr_en, pop, hit, full;

    // arm dominates every other event in its cycle
    assign full  = (count_q == FULL_CNT);
    assign wr_en = !arm && wb_valid && (state_q == TRC_PRE || state_q == TRC_POST);
    assign hit   = !arm && (state_q == TRC_PRE) &&
                   ((wb_valid && trig_pc_en && (wb_pc == trig_pc)) || trig_ext);
    assign pop   = !arm && (state_q == TRC_DONE) && rd_en && (count_q != '0);

`ifdef PPS_TRACE_TS_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle stamp, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_q <= '0;
        else      ts_q <= ts_q + TS_W'(1);
    end

    assign wr_rec = {wb_pc, wb_rd, wb_regwrite, wb_data, ts_q};
`else
    assign wr_rec = {wb_pc, wb_rd, wb_regwrite, wb_data};
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= TRC_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = TRC_PRE;
        end else begin
            case (state_q)
                TRC_PRE:  if (hit) state_d = (POST_TRIG == 0) ? TRC_DONE : TRC_POST;
                TRC_POST: if (wr_en && post_cnt == CNT_ONE) state_d = TRC_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Pointers, occupancy, post-trigger countdown and pop strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            post_cnt   <= '0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (arm) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            post_cnt   <= '0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                // When full the oldest entry is overwritten, so the read
                // pointer trails the write pointer
                if (full) rd_ptr  <= rd_ptr + PTR_ONE;
                else      count_q <= count_q + CNT_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                count_q <= count_q - CNT_ONE;
            end
            if (hit) begin
                trig_q   <= 1'b1;
                post_cnt <= POST_LD;
            end else if (wr_en && state_q == TRC_POST) begin
                post_cnt <= post_cnt - CNT_ONE;
            end
        end
    end

    // Writes and reads live in disjoint states, so one port suffices
    pps_trace_ram #(.DEPTH(DEPTH), .REC_W(REC_W)) u_ram (
        .clk   (clk),
        .en    (wr_en | pop),
        .we    (wr_en),
        .addr  (wr_en ? wr_ptr : rd_ptr),
        .wdata (wr_rec),
        .rdata (ram_q)
    );

    // RAM output is not reset; qualify it so reset forces rd_data to 0
    assign rd_data   = rd_valid_q ? ram_q : '0;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign state     = state_q;
    assign triggered = trig_q;

endmodule

// File: tb/tb_pps_trace_buf.sv
// Directed bench for pps_trace_buf. Three DEPTH=8 instances share inputs and
// differ only in POST_TRIG (2, 3, 0). Timestamp checks run when
// PPS_TRACE_TS_EN is defined.
`timescale 1ns/1ps
module tb_pps_trace_buf;
    import pps_trace_defs::*;

    localparam int PC_W   = 32;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int REC_W  = rec_w(PC_W, RD_W, DATA_W);
    localparam int PT [3] = '{2, 3, 0};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wb_valid = 1'b0;
    logic [PC_W-1:0]   wb_pc = '0;
    logic [RD_W-1:0]   wb_rd = '0;
    logic              wb_regwrite = 1'b0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              arm = 1'b0;
    logic              trig_pc_en = 1'b0;
    logic [PC_W-1:0]   trig_pc = '0;
    logic              trig_ext = 1'b0;
    logic              rd_en = 1'b0;

    logic              rdv [3];
    logic [REC_W-1:0]  rdd [3];
    logic [AW:0]       cnt [3];
    logic [1:0]        st  [3];
    logic              trg [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pps_trace_buf #(
            .PC_W(PC_W), .DATA_W(DATA_W), .RD_W(RD_W),
            .DEPTH(DEPTH), .POST_TRIG(PT[g])
        ) u_dut (
            .clk(clk), .rst(rst),
            .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
            .wb_regwrite(wb_regwrite), .wb_data(wb_data),
            .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
            .trig_ext(trig_ext), .rd_en(rd_en),
            .rd_valid(rdv[g]), .rd_data(rdd[g]), .count(cnt[g]),
            .state(st[g]), .triggered(trg[g])
        );
    end

`ifdef PPS_TRACE_TS_EN
    // Bench-side cycle count since reset release (value the next write stamps)
    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [31:0] pc);
        wb_valid    = 1'b1;
        wb_pc       = pc;
        wb_rd       = pc[6:2];
        wb_regwrite = pc[2];
        wb_data     = ~pc;
        tick();
        wb_valid    = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Pop one record from instance g and check its non-timestamp fields
    task automatic pop_chk(input int g, input logic [31:0] pc, input string tag);
        logic [REC_W-TS_W-1:0] exp;
        exp   = {pc, pc[6:2], pc[2], ~pc};
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, 128'(rdv[g]), 128'(1));
        chk(tag, 128'(rdd[g][REC_W-1:TS_W]), 128'(exp));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_state", 128'(st[0]), 128'(0));
        chk("rst_count", 128'(cnt[0]), 128'(0));
        chk("rst_trig",  128'(trg[0]), 128'(0));
        chk("rst_rdv",   128'(rdv[0]), 128'(0));
        chk("rst_rdd",   128'(rdd[0]), 128'(0));
        rst = 1'b1;
        tick();

        // IDLE ignores retirements
        retire(32'h50);
        chk("idle_count", 128'(cnt[0]), 128'(0));
        chk("idle_state", 128'(st[0]), 128'(0));

        // Basic capture, PC trigger at 0x108, POST_TRIG=2
        trig_pc_en = 1'b1;
        trig_pc    = 32'h108;
        do_arm();
        chk("t1_pre", 128'(st[0]), 128'(1));
        retire(32'h100);
        retire(32'h104);
        retire(32'h108);
        chk("t1_post", 128'(st[0]), 128'(2));
        chk("t1_trig", 128'(trg[0]), 128'(1));
        retire(32'h10C);
        retire(32'h110);
        retire(32'h114);
        retire(32'h118);
        chk("t1_done",  128'(st[0]), 128'(3));
        chk("t1_count", 128'(cnt[0]), 128'(5));
        pop_chk(0, 32'h100, "t1_pop0");
        pop_chk(0, 32'h104, "t1_pop1");
        pop_chk(0, 32'h108, "t1_pop2");
        pop_chk(0, 32'h10C, "t1_pop3");
        pop_chk(0, 32'h110, "t1_pop4");
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t1_empty_rdv", 128'(rdv[0]), 128'(0));
        chk("t1_empty_cnt", 128'(cnt[0]), 128'(0));

        // Wrap / overwrite, trigger at 0x40, POST_TRIG=3
        trig_pc = 32'h40;
        do_arm();
        for (int i = 0; i < 20; i++) retire(32'(i * 4));
        chk("t2_done",  128'(st[1]), 128'(3));
        chk("t2_count", 128'(cnt[1]), 128'(8));
        for (int i = 0; i < 8; i++) pop_chk(1, 32'h30 + 32'(i * 4), $sformatf("t2_pop%0d", i));
        chk("t2_count_end", 128'(cnt[1]), 128'(0));

        // External trigger without retire, POST_TRIG=0
        trig_pc_en = 1'b0;
        do_arm();
        retire(32'h300);
        retire(32'h304);
        retire(32'h308);
        trig_ext = 1'b1;
        tick();
        trig_ext = 1'b0;
        chk("t3_done",   128'(st[2]), 128'(3));
        chk("t3_count",  128'(cnt[2]), 128'(3));
        chk("t3_trig",   128'(trg[2]), 128'(1));
        chk("t3_p2post", 128'(st[0]), 128'(2));
        chk("t3_p2cnt",  128'(cnt[0]), 128'(3));
        pop_chk(2, 32'h300, "t3_pop0");

        // Re-arm mid-POST; arm beats a same-cycle trigger and retire
        retire(32'h30C);
        chk("t4_still_post", 128'(st[0]), 128'(2));
        arm         = 1'b1;
        trig_ext    = 1'b1;
        wb_valid    = 1'b1;
        wb_pc       = 32'h310;
        tick();
        arm         = 1'b0;
        trig_ext    = 1'b0;
        wb_valid    = 1'b0;
        chk("t4_rearm_state", 128'(st[0]), 128'(1));
        chk("t4_rearm_count", 128'(cnt[0]), 128'(0));
        chk("t4_rearm_trig",  128'(trg[0]), 128'(0));
        trig_pc_en = 1'b1;
        trig_pc    = 32'h204;
        retire(32'h200);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t4_pre_nopop", 128'(rdv[0]), 128'(0));
        chk("t4_pre_cnt",   128'(cnt[0]), 128'(1));
        retire(32'h204);
        retire(32'h208);
        retire(32'h20C);
        chk("t4_done",  128'(st[0]), 128'(3));
        chk("t4_count", 128'(cnt[0]), 128'(4));
        pop_chk(0, 32'h200, "t4_pop0");

        // Async reset between two pops: outputs clear without a clock edge
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rdv",   128'(rdv[0]), 128'(0));
        chk("t5_rdd",   128'(rdd[0]), 128'(0));
        chk("t5_count", 128'(cnt[0]), 128'(0));
        chk("t5_state", 128'(st[0]), 128'(0));
        chk("t5_trig",  128'(trg[0]), 128'(0));
        tick();
        rst = 1'b1;
        tick();
        chk("t5_idle", 128'(st[0]), 128'(0));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t5_idle_nopop", 128'(rdv[0]), 128'(0));

`ifdef PPS_TRACE_TS_EN
        // Timestamps 10 and 13 after reset release, then a wrap
        trig_pc_en = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        do_arm();
        repeat (9) tick();
        retire(32'h500);
        tick();
        tick();
        trig_ext = 1'b1;
        retire(32'h504);
        trig_ext = 1'b0;
        pop_chk(2, 32'h500, "ts_pop0");
        chk("ts_10", 128'(rdd[2][TS_W-1:0]), 128'(10));
        pop_chk(2, 32'h504, "ts_pop1");
        chk("ts_13", 128'(rdd[2][TS_W-1:0]), 128'(13));
        do_arm();
        for (int i = 0; i < 70000 && cyc[15:0] != 16'hFFFF; i++) tick();
        chk("ts_wait", 128'(cyc[15:0]), 128'(16'hFFFF));
        retire(32'hA00);
        trig_ext = 1'b1;
        retire(32'hA04);
        trig_ext = 1'b0;
        pop_chk(2, 32'hA00, "ts_wpop0");
        chk("ts_ffff", 128'(rdd[2][TS_W-1:0]), 128'(16'hFFFF));
        pop_chk(2, 32'hA04, "ts_wpop1");
        chk("ts_0000", 128'(rdd[2][TS_W-1:0]), 128'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
